// File: rtl/cache_control.sv
// Control FSM for the 2-way write-back, write-allocate L1 cache.
// Sequences hit handling, dirty-victim writeback and line refill; keeps saturating hit/miss counters.
module cache_control #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic                 tag0_hit,
    input  logic                 tag1_hit,
    input  logic                 dirty0,
    input  logic                 dirty1,
    input  logic                 lru,
    input  logic                 pmem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic                 way_sel,
    output logic                 data_load,
    output logic                 tag_load,
    output logic                 valid_load,
    output logic                 dirty_load,
    output logic                 dirty_in,
    output logic                 lru_load,
    output logic                 lru_in,
    output logic                 in_sel,
    output logic                 pmem_addr_sel,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_CHECK     = 2'd1;
    localparam logic [1:0] S_WRITEBACK = 2'd2;
    localparam logic [1:0] S_ALLOCATE  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
    logic                 refilled_q, refilled_d;

    logic req;
    logic hit;
    logic hit_way;
    logic victim_dirty;

    assign req          = mem_read | mem_write;
    assign hit          = tag0_hit | tag1_hit;
    assign hit_way      = ~tag0_hit;
    assign victim_dirty = lru ? dirty1 : dirty0;

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            refilled_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            refilled_q <= refilled_d;
        end
    end

    // Next state, counter updates and datapath strobes.
    always_comb begin
        state_d       = state_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        refilled_d    = refilled_q;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        way_sel       = 1'b0;
        data_load     = 1'b0;
        tag_load      = 1'b0;
        valid_load    = 1'b0;
        dirty_load    = 1'b0;
        dirty_in      = 1'b0;
        lru_load      = 1'b0;
        lru_in        = 1'b0;
        in_sel        = 1'b0;
        pmem_addr_sel = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                refilled_d = 1'b0;
                if (!req) begin
                    state_d = S_IDLE;
                end else if (hit) begin
                    mem_resp = 1'b1;
                    lru_load = 1'b1;
                    lru_in   = ~hit_way;
                    way_sel  = hit_way;
                    // A simultaneous read and write is serviced as a write.
                    if (mem_write) begin
                        data_load  = 1'b1;
                        in_sel     = 1'b1;
                        dirty_load = 1'b1;
                        dirty_in   = 1'b1;
                    end
                    if (!refilled_q && (hit_cnt_q != {CNT_WIDTH{1'b1}})) begin
                        hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
                    end
                    state_d = S_IDLE;
                end else begin
                    way_sel = lru;
                    if (miss_cnt_q != {CNT_WIDTH{1'b1}}) begin
                        miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
                    end
                    state_d = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = lru;
                if (pmem_resp) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                pmem_read = 1'b1;
                way_sel   = lru;
                if (pmem_resp) begin
                    data_load  = 1'b1;
                    tag_load   = 1'b1;
                    valid_load = 1'b1;
                    dirty_load = 1'b1;
                    refilled_d = 1'b1;
                    state_d    = S_CHECK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: hit vector table, miss/writeback sequences,
// reset abort and counter saturation, with a response scoreboard.
module tb_cache_control;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_read, mem_write, mem_resp;
    logic          tag0_hit, tag1_hit, dirty0, dirty1, lru, pmem_resp;
    logic          pmem_read, pmem_write, way_sel, data_load, tag_load, valid_load;
    logic          dirty_load, dirty_in, lru_load, lru_in, in_sel, pmem_addr_sel;
    logic [CW-1:0] hit_count, miss_count;
    logic [20:0]   all_o;

    cache_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .tag0_hit(tag0_hit), .tag1_hit(tag1_hit), .dirty0(dirty0), .dirty1(dirty1),
        .lru(lru), .pmem_resp(pmem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .way_sel(way_sel), .data_load(data_load), .tag_load(tag_load), .valid_load(valid_load),
        .dirty_load(dirty_load), .dirty_in(dirty_in), .lru_load(lru_load), .lru_in(lru_in),
        .in_sel(in_sel), .pmem_addr_sel(pmem_addr_sel),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    assign all_o = {mem_resp, pmem_read, pmem_write, way_sel, data_load, tag_load, valid_load,
                    dirty_load, dirty_in, lru_load, lru_in, in_sel, pmem_addr_sel,
                    hit_count, miss_count};

    typedef struct packed {
        logic way;
        logic lru_in;
        logic dl;
        logic is;
        logic dld;
        logic di;
    } resp_t;

    typedef struct {
        logic  rd;
        logic  wr;
        logic  t0;
        logic  t1;
        logic  pr;
        resp_t exp;
    } vec_t;

    resp_t exp_q[$];
    resp_t mon_e;
    logic  prev_resp = 1'b0;
    int    errors = 0;
    int    checks = 0;
    int    exp_hits = 0;
    int    exp_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every response is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mem_resp === 1'b1) begin
            chk("resp_single_pulse", 32'(prev_resp), 32'd0);
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_strobes",
                    32'({way_sel, lru_load, lru_in, data_load, in_sel, dirty_load, dirty_in,
                         pmem_read, pmem_write, tag_load, valid_load}),
                    32'({mon_e.way, 1'b1, mon_e.lru_in, mon_e.dl, mon_e.is, mon_e.dld, mon_e.di,
                         4'b0000}));
            end
        end
        prev_resp = (mem_resp === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drv;
        @(posedge clk);
        #1;
    endtask

    task automatic nedge;
        @(negedge clk);
    endtask

    task automatic bump_hit;
        if (exp_hits < 15) exp_hits++;
    endtask

    task automatic wait_resp(input int budget, output int lat);
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            nedge();
            if (mem_resp === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) chk("resp_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_hit(input vec_t v);
        int lat;
        drv();
        mem_read  = v.rd;
        mem_write = v.wr;
        tag0_hit  = v.t0;
        tag1_hit  = v.t1;
        pmem_resp = v.pr;
        exp_q.push_back(v.exp);
        bump_hit();
        wait_resp(10, lat);
        chk("hit_latency", 32'(lat), 32'd2);
        drv();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tag0_hit  = 1'b0;
        tag1_hit  = 1'b0;
        pmem_resp = 1'b0;
        nedge();
        chk("hit_count", 32'(hit_count), 32'(exp_hits));
    endtask

    vec_t vecs[7];
    int   lat;

    initial begin
        // rd wr t0 t1 pr   {way, lru_in, data_load, in_sel, dirty_load, dirty_in}
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b0_1_0000};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b1_0_1111};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'b1_0_0000};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b0_1_1111};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b1_0_1111};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b0_1_0000};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b0_1_1111};

        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; tag0_hit = 1'b0; tag1_hit = 1'b0;
        dirty0 = 1'b0; dirty1 = 1'b0; lru = 1'b0; pmem_resp = 1'b0;
        #3;
        chk("reset_outputs", 32'(all_o), 32'd0);
        drv();
        reset = 1'b0;
        nedge();
        chk("idle_outputs", 32'(all_o), 32'd0);

        for (int i = 0; i < 7; i++) do_hit(vecs[i]);

        // Back-to-back: request held through the response is re-accepted by IDLE.
        drv();
        mem_read = 1'b1; tag0_hit = 1'b1;
        exp_q.push_back(6'b0_1_0000);
        exp_q.push_back(6'b0_1_0000);
        bump_hit(); bump_hit();
        wait_resp(10, lat);
        chk("b2b_first_latency", 32'(lat), 32'd2);
        wait_resp(10, lat);
        chk("b2b_second_latency", 32'(lat), 32'd2);
        drv();
        mem_read = 1'b0; tag0_hit = 1'b0;
        nedge();
        chk("b2b_hit_count", 32'(hit_count), 32'(exp_hits));

        // Clean read miss into way1 (way0 dirty must not matter).
        drv();
        mem_read = 1'b1; lru = 1'b1; dirty1 = 1'b0; dirty0 = 1'b1;
        exp_q.push_back(6'b1_0_0000);
        exp_miss++;
        nedge();
        nedge();
        chk("clean_miss_check", 32'({mem_resp, way_sel, pmem_read, pmem_write, lru_load}), 32'b01000);
        for (int i = 0; i < 4; i++) begin
            nedge();
            chk("clean_alloc_read",
                32'({pmem_read, pmem_write, pmem_addr_sel, way_sel, data_load, tag_load}), 32'b100100);
            if (i == 0) chk("clean_miss_count", 32'(miss_count), 32'(exp_miss));
        end
        drv();
        pmem_resp = 1'b1;
        nedge();
        chk("clean_refill",
            32'({pmem_read, data_load, in_sel, tag_load, valid_load, dirty_load, dirty_in, way_sel}),
            32'b1_1_0_1_1_1_0_1);
        drv();
        pmem_resp = 1'b0; tag1_hit = 1'b1;
        nedge();
        chk("clean_recheck_resp", 32'(mem_resp), 32'd1);
        drv();
        mem_read = 1'b0; tag1_hit = 1'b0; lru = 1'b0; dirty0 = 1'b0;
        nedge();
        chk("clean_hits_unchanged", 32'(hit_count), 32'(exp_hits));
        chk("clean_miss_after", 32'(miss_count), 32'(exp_miss));

        // Dirty write miss on way0: writeback, refill, then merge on re-check.
        drv();
        mem_write = 1'b1; lru = 1'b0; dirty0 = 1'b1; dirty1 = 1'b0;
        exp_q.push_back(6'b0_1_1111);
        exp_miss++;
        nedge();
        nedge();
        chk("dirty_miss_check", 32'({mem_resp, way_sel, pmem_write, pmem_read}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            nedge();
            chk("dirty_writeback",
                32'({pmem_write, pmem_read, pmem_addr_sel, way_sel, data_load}), 32'b10100);
        end
        drv();
        pmem_resp = 1'b1;
        nedge();
        chk("wb_resp_cycle", 32'({pmem_write, pmem_addr_sel, pmem_read}), 32'b110);
        drv();
        pmem_resp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            nedge();
            chk("alloc_after_wb", 32'({pmem_read, pmem_write, pmem_addr_sel, way_sel}), 32'b1000);
        end
        drv();
        pmem_resp = 1'b1;
        nedge();
        chk("dirty_refill",
            32'({pmem_read, data_load, in_sel, tag_load, valid_load, dirty_load, dirty_in, way_sel}),
            32'b1_1_0_1_1_1_0_0);
        drv();
        pmem_resp = 1'b0; tag0_hit = 1'b1;
        nedge();
        chk("dirty_merge", 32'({mem_resp, dirty_in, in_sel}), 32'b111);
        drv();
        mem_write = 1'b0; tag0_hit = 1'b0; dirty0 = 1'b0;
        nedge();
        chk("dirty_miss_count", 32'(miss_count), 32'(exp_miss));
        chk("dirty_hits_unchanged", 32'(hit_count), 32'(exp_hits));

        // Reset asserted mid-writeback drops pmem_write immediately.
        drv();
        mem_write = 1'b1; lru = 1'b0; dirty0 = 1'b1;
        nedge();
        nedge();
        nedge();
        chk("abort_in_wb", 32'(pmem_write), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_reset_outputs", 32'(all_o), 32'd0);
        mem_write = 1'b0; dirty0 = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
        drv();
        reset = 1'b0;
        do_hit(vecs[0]);

        // Hit counter saturation.
        for (int i = 0; i < 19; i++) do_hit(vecs[5]);
        chk("hit_saturated", 32'(hit_count), 32'd15);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
